// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions.
//   wb_entry_t : one buffered write (address + data) at the default widths
//   WB_DEPTH   : default number of write-buffer entries
package mem_pkg;

    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_DEPTH      = 4;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/write_buffer.sv
// Write-through store buffer between the data cache and main memory.
// Buffers up to DEPTH writes in a circular FIFO, drains them to memory in
// push order and forwards buffered data to loads that hit a pending write.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   wr_en_i/wr_addr_i/wr_data_i  write request from the cache
//   rd_en_i/rd_addr_i          load lookup
//   mem_ack_i                  memory accepted the presented head write
//   full_o/empty_o/count_o     occupancy (registered state only)
//   stall_o                    write refused this cycle
//   fwd_hit_o/fwd_data_o       forwarding result (youngest match)
//   mem_req_o/mem_addr_o/mem_data_o  head write presented to memory
//
// Handshakes: a write is taken on a rising edge where wr_en_i=1 and
// full_o=0 (stall_o flags the refusal). The head write is retired on a
// rising edge where mem_req_o=1 and mem_ack_i=1; mem_addr_o/mem_data_o are
// held until that edge. A pop never frees space for a same-cycle push.
module write_buffer
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = WB_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [ADDR_WIDTH-1:0]    wr_addr_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  logic                     rd_en_i,
    input  logic [ADDR_WIDTH-1:0]    rd_addr_i,
    input  logic                     mem_ack_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     stall_o,
    output logic                     fwd_hit_o,
    output logic [DATA_WIDTH-1:0]    fwd_data_o,
    output logic                     mem_req_o,
    output logic [ADDR_WIDTH-1:0]    mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]         head_q;
    logic [PW-1:0]         tail_q;
    logic [CW-1:0]         count_q;
    logic                  push;
    logic                  pop;

    // Word-granular matching: the byte offset of the load is irrelevant.
    logic [1:0] unused_rd_offset;
    assign unused_rd_offset = rd_addr_i[1:0];

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Fullness is judged on registered state, so a pop cannot open a slot
    // for a write in the same cycle.
    assign push    = wr_en_i & ~full_o;
    assign pop     = mem_ack_i & ~empty_o;
    assign stall_o = wr_en_i & full_o;

    assign mem_req_o  = ~empty_o;
    assign mem_addr_o = addr_mem[head_q];
    assign mem_data_o = data_mem[head_q];

    // Pointers are PW bits wide, so DEPTH-1 -> 0 wrap is the natural overflow.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Entry storage carries no reset; occupancy decides which slots are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[tail_q] <= wr_addr_i;
            data_mem[tail_q] <= wr_data_i;
        end
    end

    // Walk live entries oldest to youngest so the last match wins. The slot
    // being written this cycle is not yet live; the head being popped still is.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_en_i && (CW'(i) < count_q) &&
                (addr_mem[head_q + PW'(i)][ADDR_WIDTH-1:2] == rd_addr_i[ADDR_WIDTH-1:2])) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_mem[head_q + PW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
module tb_write_buffer;
    import mem_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        mem_ack;
    logic        full;
    logic        empty;
    logic        stall;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    // Buffer contents as the bench believes them, oldest first.
    wb_entry_t model_q[$];
    // Writes expected at the memory port, in order.
    wb_entry_t exp_q[$];

    write_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .mem_ack_i(mem_ack),
        .full_o(full), .empty_o(empty), .stall_o(stall),
        .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .count_o(count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Check every output against the model, then advance the model by the
    // rules: push if not full (judged before any pop), pop if not empty.
    task automatic cycle(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                         input logic re, input logic [31:0] ra, input logic ack);
        bit        m_full;
        bit        m_hit;
        logic [31:0] m_fd;
        bit        do_push;
        bit        do_pop;
        wb_entry_t e;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; mem_ack = ack;
        #1;
        m_full = (model_q.size() == DEPTH);
        m_hit  = 1'b0;
        m_fd   = 32'h0;
        if (re) begin
            foreach (model_q[k]) begin
                if (model_q[k].addr[31:2] == ra[31:2]) begin
                    m_hit = 1'b1;
                    m_fd  = model_q[k].data;
                end
            end
        end
        chk("count", {29'b0, count}, model_q.size());
        chk("full", {31'b0, full}, {31'b0, m_full});
        chk("empty", {31'b0, empty}, {31'b0, model_q.size() == 0});
        chk("stall", {31'b0, stall}, {31'b0, we & m_full});
        chk("mem_req", {31'b0, mem_req}, {31'b0, model_q.size() != 0});
        chk("fwd_hit", {31'b0, fwd_hit}, {31'b0, m_hit});
        chk("fwd_data", fwd_data, m_fd);
        if (model_q.size() != 0) begin
            chk("mem_addr", mem_addr, model_q[0].addr);
            chk("mem_data", mem_data, model_q[0].data);
        end
        do_push = we && !m_full;
        do_pop  = ack && (model_q.size() != 0);
        @(posedge clk);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
            e.addr = wa;
            e.data = wd;
            model_q.push_back(e);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; mem_ack = 1'b1;
        @(posedge clk);
        model_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'h100 + {$urandom_range(0, 5), 2'b00} + 32'($urandom_range(0, 3));
    endfunction

    // Monitor: every accepted head write must be the next one pushed.
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && mem_req && mem_ack) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL drain: memory saw %h/%h with nothing expected", mem_addr, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_data !== e.data) begin
                        bad++;
                        $display("FAIL drain: got %h/%h expected %h/%h", mem_addr, mem_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        cycle(0, 0, 0, 1, 32'h100, 0);                        // reset state

        // push then drain
        cycle(1, 32'h100, 32'hAAAA0001, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h103, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);                              // ack while empty ignored

        // full stall, then pop while full still refuses the write
        for (int i = 0; i < 4; i++) cycle(1, 32'h300 + 32'(4 * i), 32'(i + 10), 0, 0, 0);
        cycle(1, 32'h400, 32'h55, 0, 0, 0);
        cycle(1, 32'h400, 32'h55, 1, 32'h308, 1);
        cycle(1, 32'h400, 32'h55, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0, 0, 1);

        // order and youngest-match forwarding
        cycle(1, 32'h200, 32'h1, 0, 0, 0);
        cycle(1, 32'h200, 32'h2, 1, 32'h202, 0);              // pushing write not forwarded
        cycle(0, 0, 0, 1, 32'h202, 0);
        cycle(0, 0, 0, 1, 32'h200, 1);                        // popping entry still forwards
        cycle(1, 32'h500, 32'h3, 0, 0, 1);                    // count 1 -> push+pop
        cycle(1, 32'h504, 32'h4, 0, 0, 0);
        repeat (6) cycle(1, 32'h600 + 32'($urandom_range(0, 15)), $urandom, 0, 0, 1); // wrap at count 2
        repeat (3) cycle(0, 0, 0, 0, 0, 1);

        // reset mid-drain
        for (int i = 0; i < 3; i++) cycle(1, 32'h700 + 32'(4 * i), 32'(i + 1), 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h704, 0);
        do_reset();
        cycle(0, 0, 0, 1, 32'h704, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            cycle($urandom_range(0, 99) < 60, rnd_addr(), $urandom,
                  $urandom_range(0, 1) == 1, rnd_addr(), $urandom_range(0, 99) < 45);
        end

        // drain, bounded
        for (int n = 0; n < 20 && model_q.size() != 0; n++) cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; DEPTH, default 4, number of entries (power of two, at least 2).
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous and active-low.
REQ-004 wr_en_i  input  1  write request; driven by the data cache's write-through enable.
REQ-005 wr_addr_i  input  ADDR_WIDTH  write address.
REQ-006 wr_data_i  input  DATA_WIDTH  write data.
REQ-007 rd_en_i  input  1  load lookup request.
REQ-008 rd_addr_i  input  ADDR_WIDTH  load address.
REQ-009 mem_ack_i  input  1  main memory has accepted the presented write.
REQ-010 full_o  output  1  buffer holds DEPTH entries.
REQ-011 empty_o  output  1  buffer holds 0 entries.
REQ-012 stall_o  output  1  write request refused this cycle; pipeline must hold.
REQ-013 fwd_hit_o  output  1  load address matches a buffered write.
REQ-014 fwd_data_o  output  DATA_WIDTH  data of the youngest matching entry.
REQ-015 mem_req_o  output  1  write pending toward main memory.
REQ-016 mem_addr_o  output  ADDR_WIDTH  head entry address.
REQ-017 mem_data_o  output  DATA_WIDTH  head entry data.
REQ-018 count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 Storage SHALL be a circular FIFO with head pointer, tail pointer and occupancy count; pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 Push SHALL occur on any edge where wr_en_i=1 and full_o=0: entry written at tail, tail advances by 1.
REQ-021 stall_o SHALL equal wr_en_i AND full_o, combinationally; a refused write SHALL not modify state.
REQ-022 mem_req_o SHALL equal NOT empty_o; mem_addr_o and mem_data_o SHALL present the head entry and stay stable until acknowledged.
REQ-023 Pop SHALL occur on any edge where mem_req_o=1 and mem_ack_i=1: head advances by 1. mem_ack_i while empty SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and perform both pointer updates.
REQ-025 When full, a pop does not enable a same-cycle push: stall_o stays 1 that cycle, and the write is accepted on the following cycle.
REQ-026 full_o, empty_o and count_o SHALL be registered-state-derived, with no combinational path from wr_en_i or mem_ack_i.
REQ-027 Forwarding SHALL be combinational: fwd_hit_o = rd_en_i AND an address match on any occupied entry; only bits [ADDR_WIDTH-1:2] are compared.
REQ-028 Forwarding priority: for multiple matches, fwd_data_o SHALL return the most recently pushed match.
REQ-029 Forwarding scope:
- An entry being popped in the current cycle SHALL still forward.
- A write being pushed in the current cycle SHALL NOT forward.
REQ-030 When fwd_hit_o=0, fwd_data_o SHALL be 0.
REQ-031 Writes SHALL drain to memory strictly in push order; no coalescing, no reordering.

Reset
REQ-032 On an edge with rst_ni=0: head=0, tail=0, count=0; from that edge full_o=0, empty_o=1, mem_req_o=0, stall_o=wr_en_i AND 0 = 0, fwd_hit_o=0.
REQ-033 Reset mid-operation SHALL discard all pending entries; an in-flight unacknowledged write SHALL be abandoned.
REQ-034 Entry storage SHALL need no reset; occupancy alone SHALL gate validity.

Structure
REQ-035 Shared package mem_pkg SHALL hold the wb_entry_t typedef (addr, data) and the default WB_DEPTH constant.
REQ-036 No sub-module: forwarding needs parallel access to every entry, so FIFO storage and comparators SHALL be inline.

Verification
REQ-037 Push then drain: push (0x100, 0xAAAA0001) with mem_ack_i=0 → mem_req_o=1, mem_addr_o=0x100, count_o=1; ack one cycle → empty_o=1 next cycle.
REQ-038 Full stall: DEPTH=4, four pushes with no ack → full_o=1, count_o=4; fifth write → stall_o=1, state unchanged; ack → write accepted next cycle.
REQ-039 Order and forwarding: push (0x200, 0x1) then (0x200, 0x2), load 0x202 → fwd_hit_o=1, fwd_data_o=0x2; drain → memory sees 0x1 then 0x2.
REQ-040 Simultaneous push/pop: count_o=2 with wr_en_i=1 and mem_ack_i=1 on the same edge → count_o=2, head and tail both advance, pointer wrap after 0x3 verified.
REQ-041 Reset mid-drain: three entries, mem_req_o=1, rst_ni=0 one edge → empty_o=1, mem_req_o=0, and a load of a previously buffered address gives fwd_hit_o=0.
